kamus_mem: RTL and testbench

- Memory/load-store stage directly downstream of the execute stage.
- Consumes the 32-bit execute result (ALU value or effective address) plus the rs2 value and decoded memory-op fields.
- Drives a request/grant/rvalid data-memory port; aligns stores, extracts and sign/zero-extends loads.
- Presents a registered writeback bundle to the register file, and stalls upstream while a memory access is outstanding.

---
 rtl/kamus_pkg.sv | 26 ++
 rtl/kamus_lsu_align.sv | 72 +++++++
 rtl/kamus_mem.sv | 156 +++++++++++++++
 tb/tb_kamus_mem.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus_mem load/store stage.
package kamus_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic: store byte-enables/data replication from the live request,
// misalignment detect, and load extract/extend from the captured request.
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  // Offset truncated to the natural alignment of the access size.
  function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    eff_off = off;
      SZ_H:    eff_off = {off[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  endfunction

  logic [1:0] w_st_off;
  logic [1:0] w_ld_off;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  assign w_st_off = eff_off(st_size_i, st_off_i);
  assign w_ld_off = eff_off(ld_size_i, ld_off_i);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be_o         = 4'hF;
    wdata_o      = st_data_i;
    misaligned_o = 1'b0;
    case (st_size_i)
      SZ_B: begin
        be_o    = 4'b0001 << w_st_off;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        be_o         = 4'b0011 << w_st_off;
        wdata_o      = {2{st_data_i[15:0]}};
        misaligned_o = st_off_i[0];
      end
      default: misaligned_o = (st_off_i != 2'b00);
    endcase
  end

  always_comb begin
    w_byte    = rdata_i[7:0];
    w_half    = w_ld_off[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = rdata_i;
    case (w_ld_off)
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      2'd3:    w_byte = rdata_i[31:24];
      default: w_byte = rdata_i[7:0];
    endcase
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{~ld_unsigned_i & w_byte[7]}}, w_byte};
      SZ_H:    ld_data_o = {{16{~ld_unsigned_i & w_half[15]}}, w_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/kamus_mem.sv
// Memory/load-store stage: req/gnt/rvalid data port, registered writeback, upstream stall.
// Optional misaligned-access trap enabled by defining KAMUS_MISALIGN_TRAP_EN.
module kamus_mem
  import kamus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mem_op_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [4:0]        rd_i,
  input  logic [31:0]       ex_i,
  input  logic [31:0]       rs2_value_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              exc_o,
  output logic [3:0]        exc_cause_o,
  output logic [31:0]       exc_addr_o
);

  state_e      r_state;
  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_ex;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;

  logic        w_accept;
  logic        w_in_req;
  logic        w_is_mem;
  logic        w_is_load;
  logic        w_trap;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic [31:0] w_ld_data;

  kamus_lsu_align u_align (
    .st_size_i     (mem_size_i),
    .st_off_i      (ex_i[1:0]),
    .st_data_i     (rs2_value_i),
    .be_o          (w_be),
    .wdata_o       (w_wdata),
    .misaligned_o  (w_misaligned),
    .ld_size_i     (r_size),
    .ld_off_i      (r_ex[1:0]),
    .ld_unsigned_i (r_unsigned),
    .rdata_i       (dmem_rdata_i),
    .ld_data_o     (w_ld_data)
  );

  // Held low during reset so every output is 0 while rst_i is asserted.
  assign ready_o   = (r_state == ST_IDLE) & ~rst_i;
  assign w_accept  = valid_i & ready_o;
  assign w_is_load = (mem_op_i == MEM_LOAD);
  assign w_is_mem  = w_is_load | (mem_op_i == MEM_STORE);
  assign w_in_req  = (r_state == ST_REQ);

`ifdef KAMUS_MISALIGN_TRAP_EN
  logic        r_exc;
  logic [3:0]  r_exc_cause;

  assign w_trap = w_is_mem & w_misaligned;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exc       <= 1'b0;
      r_exc_cause <= 4'd0;
    end else if (w_accept) begin
      r_exc       <= w_trap;
      r_exc_cause <= w_is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
    end
  end

  assign exc_o       = (r_state == ST_DONE) & r_exc;
  assign exc_cause_o = exc_o ? r_exc_cause : 4'd0;
  assign exc_addr_o  = exc_o ? r_ex : 32'd0;
`else
  logic w_unused_misaligned;
  assign w_unused_misaligned = w_misaligned;
  assign w_trap      = 1'b0;
  assign exc_o       = 1'b0;
  assign exc_cause_o = 4'd0;
  assign exc_addr_o  = 32'd0;
`endif

  // NOTE: the async reset clears only control/capture flops; there is no storage array here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_ex       <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all updates see pre-edge values.
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_is_store <= (mem_op_i == MEM_STORE);
          r_size     <= mem_size_i;
          r_unsigned <= mem_unsigned_i;
          r_ex       <= ex_i;
          r_be       <= w_be;
          r_wdata    <= w_wdata;
          r_wb_rd    <= rd_i;
          r_wb_data  <= ex_i;
          r_wb_we    <= (rd_i != 5'd0) & (mem_op_i != MEM_STORE) & ~w_trap;
          r_state    <= (w_is_mem & ~w_trap) ? ST_REQ : ST_DONE;
        end
        ST_REQ: if (dmem_gnt_i) begin
          r_state <= r_is_store ? ST_DONE : ST_WAIT_R;
        end
        ST_WAIT_R: if (dmem_rvalid_i) begin
          r_wb_data <= w_ld_data;
          r_state   <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_o   = w_in_req;
  assign dmem_we_o    = w_in_req & r_is_store;
  assign dmem_addr_o  = w_in_req ? {r_ex[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be_o    = w_in_req ? r_be : 4'd0;
  assign dmem_wdata_o = w_in_req ? r_wdata : 32'd0;

  assign wb_valid_o = (r_state == ST_DONE);
  assign wb_we_o    = r_wb_we;
  assign wb_rd_o    = r_wb_rd;
  assign wb_data_o  = r_wb_data;

endmodule

// File: tb/tb_kamus_mem.sv
// Directed self-checking bench for kamus_mem; expectations follow the trap feature macro.
module tb_kamus_mem;
  import kamus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  mem_op_i = 2'd0;
  logic [1:0]  mem_size_i = 2'd0;
  logic        mem_unsigned_i = 1'b0;
  logic [4:0]  rd_i = 5'd0;
  logic [31:0] ex_i = 32'd0;
  logic [31:0] rs2_value_i = 32'd0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'd0;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_addr_o;

  int checks = 0;
  int errors = 0;

  kamus_mem #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .rd_i(rd_i), .ex_i(ex_i), .rs2_value_i(rs2_value_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request and let it be accepted on the next edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] rs2);
    mem_op_i = op; mem_size_i = size; mem_unsigned_i = uns;
    rd_i = rd; ex_i = ex; rs2_value_i = rs2; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  // From REQ: immediate grant, rvalid next cycle, ends in DONE.
  task automatic grant_and_return(input logic [31:0] rdata);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_exc", {31'd0, exc_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, ready_o}, 32'd1);

    // MEM_NONE rd=5: writeback next cycle, ready low for one cycle
    issue(MEM_NONE, SZ_W, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
    check("none_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("none_wb_we", {31'd0, wb_we_o}, 32'd1);
    check("none_wb_rd", {27'd0, wb_rd_o}, 32'd5);
    check("none_wb_data", wb_data_o, 32'h0000_1234);
    check("none_ready_low", {31'd0, ready_o}, 32'd0);
    check("none_req", {31'd0, dmem_req_o}, 32'd0);
    tick();
    check("none_ready_back", {31'd0, ready_o}, 32'd1);
    check("none_wb_pulse_end", {31'd0, wb_valid_o}, 32'd0);

    // MEM_NONE rd=0: no register write
    issue(MEM_NONE, SZ_W, 1'b0, 5'd0, 32'h0000_0055, 32'd0);
    check("none_rd0_we", {31'd0, wb_we_o}, 32'd0);
    tick();

    // Store SZ_H at 0x102, grant arrives in the third REQ cycle
    issue(MEM_STORE, SZ_H, 1'b0, 5'd9, 32'h0000_0102, 32'hABCD_5678);
    for (int i = 0; i < 3; i++) begin
      check("sth_req", {31'd0, dmem_req_o}, 32'd1);
      check("sth_we", {31'd0, dmem_we_o}, 32'd1);
      check("sth_addr", dmem_addr_o, 32'h0000_0100);
      check("sth_be", {28'd0, dmem_be_o}, 32'h0000_000C);
      check("sth_wdata", dmem_wdata_o, 32'h5678_5678);
      check("sth_ready", {31'd0, ready_o}, 32'd0);
      if (i == 2) dmem_gnt_i = 1'b1;
      tick();
    end
    dmem_gnt_i = 1'b0;
    check("sth_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("sth_wb_we", {31'd0, wb_we_o}, 32'd0);
    check("sth_req_drop", {31'd0, dmem_req_o}, 32'd0);
    tick();

    // Store SZ_B at 0x001: lane 1, byte replicated
    issue(MEM_STORE, SZ_B, 1'b0, 5'd1, 32'h0000_0001, 32'h1234_56AB);
    check("stb_be", {28'd0, dmem_be_o}, 32'h0000_0002);
    check("stb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    check("stb_addr", dmem_addr_o, 32'h0000_0000);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("stb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    tick();

    // Load SZ_B signed at 0x203
    issue(MEM_LOAD, SZ_B, 1'b0, 5'd7, 32'h0000_0203, 32'd0);
    check("lb_req", {31'd0, dmem_req_o}, 32'd1);
    check("lb_we", {31'd0, dmem_we_o}, 32'd0);
    check("lb_addr", dmem_addr_o, 32'h0000_0200);
    check("lb_be", {28'd0, dmem_be_o}, 32'h0000_0008);
    grant_and_return(32'h80FF_0000);
    check("lb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("lb_wb_we", {31'd0, wb_we_o}, 32'd1);
    check("lb_wb_rd", {27'd0, wb_rd_o}, 32'd7);
    check("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
    tick();

    // Same byte, unsigned
    issue(MEM_LOAD, SZ_B, 1'b1, 5'd7, 32'h0000_0203, 32'd0);
    grant_and_return(32'h80FF_0000);
    check("lbu_wb_data", wb_data_o, 32'h0000_0080);
    tick();

    // Load SZ_H signed at 0x206: upper half
    issue(MEM_LOAD, SZ_H, 1'b0, 5'd8, 32'h0000_0206, 32'd0);
    check("lh_be", {28'd0, dmem_be_o}, 32'h0000_000C);
    grant_and_return(32'h8001_1234);
    check("lh_wb_data", wb_data_o, 32'hFFFF_8001);
    tick();

    // Load SZ_W, rvalid four cycles after grant, valid_i held high throughout
    mem_op_i = MEM_LOAD; mem_size_i = SZ_W; mem_unsigned_i = 1'b0;
    rd_i = 5'd9; ex_i = 32'h0000_0400; valid_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("lw_wait_ready", {31'd0, ready_o}, 32'd0);
      check("lw_wait_req", {31'd0, dmem_req_o}, 32'd0);
      check("lw_wait_wb", {31'd0, wb_valid_o}, 32'd0);
      if (i == 3) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
      end
      tick();
    end
    dmem_rvalid_i = 1'b0;
    check("lw_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("lw_wb_data", wb_data_o, 32'hDEAD_BEEF);
    check("lw_done_ready", {31'd0, ready_o}, 32'd0);
    tick();
    check("lw_idle_ready", {31'd0, ready_o}, 32'd1);
    check("lw_idle_wb", {31'd0, wb_valid_o}, 32'd0);
    check("lw_no_reaccept", {31'd0, dmem_req_o}, 32'd0);
    valid_i = 1'b0;
    tick();

    // Reset while in WAIT_R with rvalid, then a late rvalid after reset
    issue(MEM_LOAD, SZ_W, 1'b0, 5'd4, 32'h0000_0500, 32'd0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h0BAD_0BAD;
    #1;
    check("mid_rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("mid_rst_wb", {31'd0, wb_valid_o}, 32'd0);
    check("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    check("mid_rst_wb_data", wb_data_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("late_rvalid_wb", {31'd0, wb_valid_o}, 32'd0);
    check("late_rvalid_ready", {31'd0, ready_o}, 32'd1);
    check("late_rvalid_req", {31'd0, dmem_req_o}, 32'd0);
    dmem_rvalid_i = 1'b0;
    tick();

`ifdef KAMUS_MISALIGN_TRAP_EN
    // Misaligned load word: trap, no request
    issue(MEM_LOAD, SZ_W, 1'b0, 5'd3, 32'h0000_0301, 32'd0);
    check("mis_lw_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_lw_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("mis_lw_wb_we", {31'd0, wb_we_o}, 32'd0);
    check("mis_lw_exc", {31'd0, exc_o}, 32'd1);
    check("mis_lw_cause", {28'd0, exc_cause_o}, 32'd4);
    check("mis_lw_addr", exc_addr_o, 32'h0000_0301);
    tick();
    check("mis_lw_exc_end", {31'd0, exc_o}, 32'd0);
    // Misaligned store half: trap with store cause
    issue(MEM_STORE, SZ_H, 1'b0, 5'd3, 32'h0000_0103, 32'h0000_1111);
    check("mis_sh_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_sh_exc", {31'd0, exc_o}, 32'd1);
    check("mis_sh_cause", {28'd0, exc_cause_o}, 32'd6);
    check("mis_sh_addr", exc_addr_o, 32'h0000_0103);
    tick();
`else
    // Misaligned load word: truncated to the word and performed
    issue(MEM_LOAD, SZ_W, 1'b0, 5'd3, 32'h0000_0301, 32'd0);
    check("mis_lw_req", {31'd0, dmem_req_o}, 32'd1);
    check("mis_lw_addr", dmem_addr_o, 32'h0000_0300);
    check("mis_lw_be", {28'd0, dmem_be_o}, 32'h0000_000F);
    check("mis_lw_exc", {31'd0, exc_o}, 32'd0);
    grant_and_return(32'h1122_3344);
    check("mis_lw_wb_data", wb_data_o, 32'h1122_3344);
    check("mis_lw_wb_we", {31'd0, wb_we_o}, 32'd1);
    check("mis_lw_exc_done", {31'd0, exc_o}, 32'd0);
    tick();
    // Misaligned store half: offset bit 0 cleared
    issue(MEM_STORE, SZ_H, 1'b0, 5'd3, 32'h0000_0103, 32'h0000_1111);
    check("mis_sh_addr", dmem_addr_o, 32'h0000_0100);
    check("mis_sh_be", {28'd0, dmem_be_o}, 32'h0000_000C);
    check("mis_sh_wdata", dmem_wdata_o, 32'h1111_1111);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check("mis_sh_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
